// File: rtl/shifter_pipe.sv
// Pipelined log-shifter/rotator (LSL, ROL, LSR, ASR, ROR, pass-through) with valid/ready flow control.
// Define SHIFTER_FLAGS_EN to add the registered Zero and CarryOut outputs.
module shifter_pipe #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     Flush,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [WIDTH-1:0]         DataA,
    input  logic [$clog2(WIDTH)-1:0] ShiftAmount,
    input  logic [2:0]               Mode,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [WIDTH-1:0]         Result
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic                     Zero,
    output logic                     CarryOut
`endif
);

    localparam int unsigned AW     = $clog2(WIDTH);
    localparam int unsigned LEVELS = AW;
    localparam int unsigned LPS    = (LEVELS + PIPE_STAGES - 1) / PIPE_STAGES;

    localparam logic [2:0] M_LSL = 3'd0;
    localparam logic [2:0] M_ROL = 3'd1;
    localparam logic [2:0] M_LSR = 3'd2;
    localparam logic [2:0] M_ASR = 3'd3;
    localparam logic [2:0] M_ROR = 3'd4;

    logic [PIPE_STAGES-1:0] valid_q;
    logic [WIDTH-1:0]       data_q [PIPE_STAGES];
    logic [AW-1:0]          amt_q  [PIPE_STAGES];
    logic [2:0]             mode_q [PIPE_STAGES];
    logic [WIDTH-1:0]       data_d [PIPE_STAGES];
    logic                   adv_c;

    // One log-shifter level: move by 2**k in the direction/fill of the mode.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       mode,
        input int unsigned      k
    );
        int unsigned sh;
        logic [WIDTH-1:0] r;
        sh = 32'd1 << k;
        case (mode)
            M_LSL:   r = d << sh;
            M_ROL:   r = (d << sh) | (d >> (WIDTH - sh));
            M_LSR:   r = d >> sh;
            M_ASR:   r = $signed(d) >>> sh;
            M_ROR:   r = (d >> sh) | (d << (WIDTH - sh));
            default: r = d;
        endcase
        return r;
    endfunction

    // Apply the levels owned by one pipeline stage; later stages may own none.
    function automatic logic [WIDTH-1:0] run_levels(
        input logic [WIDTH-1:0] d,
        input logic [AW-1:0]    amt,
        input logic [2:0]       mode,
        input int unsigned      stage
    );
        logic [WIDTH-1:0] r;
        r = d;
        for (int unsigned k = 0; k < LEVELS; k++) begin
            if (k >= stage * LPS && k < (stage + 1) * LPS &&
                ((amt >> k) & AW'(1)) != '0) begin
                r = shift_level(r, mode, k);
            end
        end
        return r;
    endfunction

    assign adv_c    = !valid_q[PIPE_STAGES-1] || OutReady;
    assign InReady  = adv_c;
    assign OutValid = valid_q[PIPE_STAGES-1];
    assign Result   = data_q[PIPE_STAGES-1];

    // Per-stage shifter network.
    always_comb begin
        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            data_d[s] = '0;
        end
        data_d[0] = run_levels(DataA, ShiftAmount, Mode, 0);
        for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
            data_d[s] = run_levels(data_q[s-1], amt_q[s-1], mode_q[s-1], s);
        end
    end

    // Valid bits follow the global advance; Flush wins over an accept.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= '0;
        end else if (Flush) begin
            valid_q <= '0;
        end else if (adv_c) begin
            valid_q[0] <= InValid;
            for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    // Data, mode and amount travel together and move only on advance.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
                data_q[s] <= '0;
                amt_q[s]  <= '0;
                mode_q[s] <= '0;
            end
        end else if (adv_c) begin
            data_q[0] <= data_d[0];
            amt_q[0]  <= ShiftAmount;
            mode_q[0] <= Mode;
            for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
                data_q[s] <= data_d[s];
                amt_q[s]  <= amt_q[s-1];
                mode_q[s] <= mode_q[s-1];
            end
        end
    end

`ifdef SHIFTER_FLAGS_EN
    logic [PIPE_STAGES-1:0] carry_q;
    logic                   zero_q;
    logic                   early_c;
    logic                   cout_c;
    logic [AW-1:0]          last_amt;
    logic [2:0]             last_mode;
    logic                   last_carry;
    logic [AW-1:0]          lsl_idx;
    logic [AW-1:0]          lsr_idx;

    // Shift-out bit for LSL/LSR/ASR must be captured from the original operand.
    assign lsl_idx = ~ShiftAmount + AW'(1);
    assign lsr_idx = ShiftAmount - AW'(1);

    always_comb begin
        early_c = 1'b0;
        if (ShiftAmount != '0) begin
            case (Mode)
                M_LSL:        early_c = DataA[lsl_idx];
                M_LSR, M_ASR: early_c = DataA[lsr_idx];
                default:      early_c = 1'b0;
            endcase
        end
    end

    if (PIPE_STAGES == 1) begin : g_last_src_in
        assign last_amt   = ShiftAmount;
        assign last_mode  = Mode;
        assign last_carry = early_c;
    end else begin : g_last_src_pipe
        assign last_amt   = amt_q[PIPE_STAGES-2];
        assign last_mode  = mode_q[PIPE_STAGES-2];
        assign last_carry = carry_q[PIPE_STAGES-2];
    end

    // Rotates take their carry from the finished result.
    always_comb begin
        cout_c = 1'b0;
        if (last_amt != '0) begin
            case (last_mode)
                M_ROL:               cout_c = data_d[PIPE_STAGES-1][0];
                M_ROR:               cout_c = data_d[PIPE_STAGES-1][WIDTH-1];
                M_LSL, M_LSR, M_ASR: cout_c = last_carry;
                default:             cout_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            carry_q <= '0;
            zero_q  <= 1'b0;
        end else if (adv_c) begin
            carry_q[0] <= (PIPE_STAGES == 1) ? cout_c : early_c;
            for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
                carry_q[s] <= (s == PIPE_STAGES - 1) ? cout_c : carry_q[s-1];
            end
            zero_q <= (data_d[PIPE_STAGES-1] == '0);
        end
    end

    assign Zero     = zero_q;
    assign CarryOut = carry_q[PIPE_STAGES-1];
`endif

endmodule
